// File: rtl/relu_pkg.sv
// relu_pkg: shared types and per-lane arithmetic for relu_drain_ctrl.
//   state_t  : controller states IDLE -> DRAIN -> DONE
//   OUT_W    : activation width, {1'b0, 8-bit magnitude}
//   relu_q   : one-lane ReLU + quantise (window acc[slice-1:slice-8])
//   relu_hi  : any non-sign bit above the quantise window is set
// Optional feature macro: RELU_SAT_EN (clamp overflowing lanes to 9'h0FF).
package relu_pkg;

   typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

   localparam int unsigned OUT_W = 9;

   // Callers pass the accumulator zero-extended to 64 bits.
   // The mask covers acc[acc_w-2:slice] and is empty when slice == acc_w-1.
   function automatic logic relu_hi(input logic [63:0] acc,
                                    input int unsigned acc_w,
                                    input int unsigned slice);
      logic [63:0] mask;
      mask = (64'd1 << (acc_w - 1 - slice)) - 64'd1;
      return |((acc >> slice) & mask);
   endfunction

   function automatic logic [OUT_W-1:0] relu_q(input logic [63:0] acc,
                                               input int unsigned acc_w,
                                               input int unsigned slice);
      logic       neg;
      logic [7:0] mag;
      neg = 1'(acc >> (acc_w - 1));
      mag = 8'(acc >> (slice - 8));
      if (neg) return '0;
`ifdef RELU_SAT_EN
      if (relu_hi(acc, acc_w, slice)) return 9'h0FF;
`endif
      return {1'b0, mag};
   endfunction

endpackage

// File: rtl/relu_drain_ctrl_if.sv
// relu_drain_ctrl_if: accumulator capture stream and activation output stream.
//   acc_valid/acc_ready/acc_data          : vector in (lane 0 in the low bits)
//   out_valid/out_ready/out_data/out_idx/
//   out_last                              : activation beats out
// modport master : the controller side
// modport slave  : the producer/consumer environment side
interface relu_drain_ctrl_if
   import relu_pkg::*;
#(
   parameter int unsigned ROWS  = 64,
   parameter int unsigned ACC_W = 26,
   parameter int unsigned LANES = 8
);
   localparam int unsigned IDX_W = $clog2(ROWS / LANES);

   logic                              acc_valid;
   logic                              acc_ready;
   logic [ROWS-1:0][ACC_W-1:0]        acc_data;
   logic                              out_valid;
   logic                              out_ready;
   logic [LANES-1:0][OUT_W-1:0]       out_data;
   logic [IDX_W-1:0]                  out_idx;
   logic                              out_last;

   modport master (
      input  acc_valid, acc_data, out_ready,
      output acc_ready, out_valid, out_data, out_idx, out_last
   );

   modport slave (
      output acc_valid, acc_data, out_ready,
      input  acc_ready, out_valid, out_data, out_idx, out_last
   );

endinterface

// File: rtl/relu_lane.sv
// relu_lane: combinational ReLU/quantiser for one accumulator lane.
//   acc : signed accumulator, ACC_W bits
//   q   : activation {1'b0, acc[SLICE-1:SLICE-8]}, 0 for negative lanes
//   sat : lane overflowed the window (present only with RELU_SAT_EN)
module relu_lane
   import relu_pkg::*;
#(
   parameter int unsigned ACC_W = 26,
   parameter int unsigned SLICE = 21
)(
   input  logic [ACC_W-1:0] acc,
   output logic [OUT_W-1:0] q
`ifdef RELU_SAT_EN
   ,output logic            sat
`endif
);

   assign q = relu_q(64'(acc), ACC_W, SLICE);

`ifdef RELU_SAT_EN
   assign sat = !acc[ACC_W-1] && relu_hi(64'(acc), ACC_W, SLICE);
`endif

endmodule

// File: rtl/relu_drain_ctrl.sv
// relu_drain_ctrl: captures one ROWS-lane accumulator vector and drains it as
// ROWS/LANES beats of LANES activations over a valid/ready stream.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : relu_drain_ctrl_if.master (acc_* capture, out_* beats)
//   busy       : high while draining
//   done       : one-cycle pulse after the final beat is accepted
//   sat_seen   : a lane saturated in the current vector (RELU_SAT_EN only)
// Optional feature macro: RELU_SAT_EN.
module relu_drain_ctrl
   import relu_pkg::*;
#(
   parameter int unsigned ROWS  = 64,
   parameter int unsigned ACC_W = 26,
   parameter int unsigned SLICE = 21,
   parameter int unsigned LANES = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   relu_drain_ctrl_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              sat_seen
);

   localparam int unsigned      NBEATS = ROWS / LANES;
   localparam int unsigned      IDX_W  = $clog2(NBEATS);
   localparam logic [IDX_W-1:0] LAST   = IDX_W'(NBEATS - 1);

   state_t                                 state_q, state_d;
   logic [IDX_W-1:0]                       beat_q, beat_d;
   // Capture register viewed as [beat][lane] so the beat mux is a plain index.
   logic [NBEATS-1:0][LANES-1:0][ACC_W-1:0] cap_q;
   logic                                   capture;
   logic                                   accept;
   logic [LANES-1:0][OUT_W-1:0]            lane_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   // Data is only meaningful after a capture, so it needs no reset.
   always_ff @(posedge clk) begin
      if (capture) cap_q <= bus.acc_data;
   end

   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      bus.acc_ready = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      capture       = 1'b0;
      accept        = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Held low while reset is asserted so nothing is captured then.
            bus.acc_ready = rst_n;
            if (bus.acc_valid && rst_n) begin
               capture = 1'b1;
               beat_d  = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            bus.out_valid = 1'b1;
            busy          = 1'b1;
            if (bus.out_ready) begin
               accept = 1'b1;
               if (beat_q == LAST) begin
                  beat_d  = '0;
                  state_d = DONE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef RELU_SAT_EN
   logic [LANES-1:0] lane_sat;
`endif

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      relu_lane #(.ACC_W(ACC_W), .SLICE(SLICE)) u_lane (
         .acc (cap_q[beat_q][k]),
         .q   (lane_q[k])
`ifdef RELU_SAT_EN
         ,.sat(lane_sat[k])
`endif
      );
   end

   assign bus.out_data = lane_q;
   assign bus.out_idx  = beat_q;
   assign bus.out_last = (state_q == DRAIN) && (beat_q == LAST);

`ifdef RELU_SAT_EN
   logic sat_q;

   always_ff @(posedge clk) begin
      if (!rst_n)                   sat_q <= 1'b0;
      else if (capture)             sat_q <= 1'b0;
      else if (accept && |lane_sat) sat_q <= 1'b1;
   end

   assign sat_seen = sat_q;
`else
   assign sat_seen = 1'b0;
`endif

endmodule

// File: tb/tb_relu_drain_ctrl.sv
// tb_relu_drain_ctrl: directed + randomized bench for relu_drain_ctrl using the
// default geometry (ROWS=64, ACC_W=26, SLICE=21, LANES=8). Expected activations
// come from an arithmetic reference of the lane rule. Honours RELU_SAT_EN.
module tb_relu_drain_ctrl;

   localparam int ROWS  = 64;
   localparam int ACC_W = 26;
   localparam int SLICE = 21;
   localparam int LANES = 8;
   localparam int NB    = ROWS / LANES;

   logic clk = 1'b0;
   logic rst_n;
   logic busy, done, sat_seen;

   int tests = 0;
   int fails = 0;

   logic [25:0] cur_vec [ROWS];
   logic [25:0] nxt_vec [ROWS];

   always #5 clk = ~clk;

   relu_drain_ctrl_if #(.ROWS(ROWS), .ACC_W(ACC_W), .LANES(LANES)) bus ();

   relu_drain_ctrl #(.ROWS(ROWS), .ACC_W(ACC_W), .SLICE(SLICE), .LANES(LANES)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .sat_seen (sat_seen)
   );

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference lane rule, plain integer arithmetic on the unsigned lane value.
   function automatic logic [8:0] ref_q(input logic [25:0] a);
      longint v;
      v = longint'(a);
      if (v >= (longint'(1) << 25)) return 9'h000;
`ifdef RELU_SAT_EN
      if (v >= (longint'(1) << SLICE)) return 9'h0FF;
`endif
      return 9'((v / 8192) % 256);
   endfunction

   function automatic bit ref_sat(input logic [25:0] a);
`ifdef RELU_SAT_EN
      longint v;
      v = longint'(a);
      return (v < (longint'(1) << 25)) && (v >= (longint'(1) << SLICE));
`else
      return (a != a);
`endif
   endfunction

   function automatic logic [71:0] ref_beat(input int b);
      logic [LANES-1:0][8:0] e;
      for (int k = 0; k < LANES; k++) e[3'(k)] = ref_q(cur_vec[b * LANES + k]);
      return 72'(e);
   endfunction

   function automatic bit ref_beat_sat(input int b);
      bit s = 0;
      for (int k = 0; k < LANES; k++) s |= ref_sat(cur_vec[b * LANES + k]);
      return s;
   endfunction

   task automatic drive_vec(input logic [25:0] v [ROWS]);
      for (int i = 0; i < ROWS; i++) bus.acc_data[6'(i)] = v[i];
   endtask

   // Entered and left at a negedge with the controller in IDLE.
   task automatic run_vector(input string name, input int pct, input bit hold);
      int  cyc;
      int  exp_b;
      bit  rdy;
      bit  exp_sat;
      drive_vec(cur_vec);
      bus.acc_valid = 1'b1;
      cyc = 0;
      while (bus.acc_ready !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      tests++;
      assert (cyc < 50) else begin
         fails++;
         $error("FAIL %s_capture_timeout: waited %0d cycles, limit 50", name, cyc);
      end
      @(negedge clk);
      if (!hold) bus.acc_valid = 1'b0;
      exp_b   = 0;
      exp_sat = 0;
      cyc     = 0;
      while (exp_b < NB && cyc < 400) begin
         check({name, "_valid"}, 72'(bus.out_valid), 72'(1'b1));
         check({name, "_idx"},   72'(bus.out_idx),   72'(exp_b));
         check({name, "_last"},  72'(bus.out_last),  72'(exp_b == NB - 1));
         check({name, "_data"},  72'(bus.out_data),  ref_beat(exp_b));
         check({name, "_busy"},  72'(busy),          72'(1'b1));
         check({name, "_ardy"},  72'(bus.acc_ready), 72'(1'b0));
         check({name, "_sat"},   72'(sat_seen),      72'(exp_sat));
         rdy = ($urandom_range(99) < pct);
         bus.out_ready = rdy;
         @(negedge clk);
         if (rdy) begin
            exp_sat |= ref_beat_sat(exp_b);
            exp_b++;
         end
         cyc++;
      end
      bus.out_ready = 1'b0;
      tests++;
      assert (exp_b == NB) else begin
         fails++;
         $error("FAIL %s_drain_timeout: beats %0d, required %0d", name, exp_b, NB);
      end
      check({name, "_done"},      72'(done),          72'(1'b1));
      check({name, "_done_valid"},72'(bus.out_valid), 72'(1'b0));
      check({name, "_done_ardy"}, 72'(bus.acc_ready), 72'(1'b0));
      check({name, "_done_sat"},  72'(sat_seen),      72'(exp_sat));
      if (hold) drive_vec(nxt_vec);
      @(negedge clk);
      check({name, "_idle_done"}, 72'(done),          72'(1'b0));
      check({name, "_idle_ardy"}, 72'(bus.acc_ready), 72'(1'b1));
      check({name, "_idle_busy"}, 72'(busy),          72'(1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus.acc_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.acc_data  = '0;
      @(posedge clk);
      @(negedge clk);
      check("rst_ardy",  72'(bus.acc_ready), 72'(1'b0));
      check("rst_valid", 72'(bus.out_valid), 72'(1'b0));
      check("rst_last",  72'(bus.out_last),  72'(1'b0));
      check("rst_idx",   72'(bus.out_idx),   72'(0));
      check("rst_busy",  72'(busy),          72'(1'b0));
      check("rst_done",  72'(done),          72'(1'b0));
      check("rst_sat",   72'(sat_seen),      72'(1'b0));
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ardy", 72'(bus.acc_ready), 72'(1'b1));

      // Ramp: lane k = k<<13 gives activation k.
      for (int i = 0; i < ROWS; i++) cur_vec[i] = 26'(i << 13);
      run_vector("ramp", 100, 1'b0);

      // Boundary lanes: -1, most negative, max window, bit SLICE set.
      for (int i = 0; i < ROWS; i++) cur_vec[i] = 26'($urandom);
      cur_vec[0] = 26'h3FFFFFF;
      cur_vec[1] = 26'h2000000;
      cur_vec[2] = 26'h01FE000;
      cur_vec[3] = 26'h0200000;
      cur_vec[4] = 26'h1FFFFFF;
      cur_vec[5] = 26'h0000000;
      run_vector("edge", 100, 1'b0);

      // Random data with random back-pressure.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < ROWS; i++)
            cur_vec[i] = (i % 3 == 0) ? 26'($urandom) : 26'($urandom_range(26'h1FFFFF));
         run_vector("rand", 50, 1'b0);
      end

      // Reset in the middle of beat 3.
      for (int i = 0; i < ROWS; i++) cur_vec[i] = 26'(i << 13);
      drive_vec(cur_vec);
      bus.acc_valid = 1'b1;
      @(negedge clk);
      bus.acc_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_idx3", 72'(bus.out_idx), 72'(3));
      rst_n = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("mid_rst_valid", 72'(bus.out_valid), 72'(1'b0));
      check("mid_rst_idx",   72'(bus.out_idx),   72'(0));
      check("mid_rst_done",  72'(done),          72'(1'b0));
      check("mid_rst_busy",  72'(busy),          72'(1'b0));
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_post_done", 72'(done),          72'(1'b0));
      check("mid_post_ardy", 72'(bus.acc_ready), 72'(1'b1));
      for (int i = 0; i < ROWS; i++) cur_vec[i] = 26'($urandom_range(26'h1FFFFF));
      run_vector("after_rst", 100, 1'b0);

      // acc_valid held through DRAIN: next vector only taken from IDLE.
      for (int i = 0; i < ROWS; i++) cur_vec[i] = 26'($urandom_range(26'h1FFFFF));
      for (int i = 0; i < ROWS; i++) nxt_vec[i] = 26'($urandom);
      run_vector("hold1", 70, 1'b1);
      for (int i = 0; i < ROWS; i++) cur_vec[i] = nxt_vec[i];
      run_vector("hold2", 100, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
